// File: rtl/platform_scroller.sv
// Platform field owner: builds the initial layout, scrolls platforms on request
// from the jump block, respawns fallen platforms at the top and keeps the score.
`timescale 1ns/1ps
module platform_scroller #(
    parameter int unsigned N_PLAT       = 16,
    parameter int unsigned SCROLL_SHIFT = 2,
    parameter int unsigned D_MAX        = 63,
    parameter int unsigned Y_MAX        = 479,
    parameter int unsigned Y_SPAN       = 480,
    parameter int unsigned LOAD_Y0      = 15,
    parameter int unsigned LOAD_DY      = 30,
    parameter int unsigned X_MIN        = 64,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                         frame_clk,
    input  logic                         Reset,
    input  logic                         loadplat,
    input  logic                         refresh_en,
    input  logic [9:0]                   plat_temp_Y,
    output logic                         trigger,
    output logic                         busy,
    output logic [N_PLAT-1:0][8:0]       plat_x,
    output logic [N_PLAT-1:0][8:0]       plat_y,
    output logic [15:0]                  scroll_total
);

    typedef enum logic [1:0] {IDLE, LOAD, SCROLL, DONE} state_t;

    state_t      state;
    logic [3:0]  idx;
    logic        served;
    logic [15:0] lfsr;
    logic [5:0]  d;

    logic [9:0]  neg_m;
    logic [11:0] scaled;
    logic [5:0]  d_in;
    logic [8:0]  r;
    logic [8:0]  gen_x;
    logic [15:0] lfsr_next;
    logic [9:0]  s;
    logic [16:0] total_sum;
    logic [8:0]  load_y;
    logic        last;

    always_comb begin
        neg_m     = ~plat_temp_Y + 10'd1;
        scaled    = {2'b00, neg_m} << SCROLL_SHIFT;
        d_in      = '0;
        if (plat_temp_Y[9])
            d_in = (scaled > 12'(D_MAX)) ? 6'(D_MAX) : scaled[5:0];
        // Folding the top 64 values of r back keeps X inside 64..511
        r         = lfsr[8:0];
        gen_x     = 9'(X_MIN) + ((r >= 9'd448) ? (r - 9'd256) : r);
        lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        s         = {1'b0, plat_y[idx]} + {4'b0000, d};
        total_sum = {1'b0, scroll_total} + {11'b0, d};
        load_y    = 9'(LOAD_Y0) + 9'(LOAD_DY) * {5'b00000, idx};
        last      = (idx == 4'(N_PLAT - 1));
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            idx          <= '0;
            served       <= 1'b0;
            lfsr         <= LFSR_SEED;
            d            <= '0;
            trigger      <= 1'b0;
            busy         <= 1'b0;
            plat_x       <= '0;
            plat_y       <= '0;
            scroll_total <= '0;
        end else begin
            trigger <= 1'b0;
            if (!refresh_en)
                served <= 1'b0;
            case (state)
                IDLE: begin
                    if (loadplat) begin
                        state        <= LOAD;
                        busy         <= 1'b1;
                        idx          <= '0;
                        scroll_total <= '0;
                    end else if (refresh_en && !served) begin
                        state <= SCROLL;
                        busy  <= 1'b1;
                        idx   <= '0;
                        d     <= d_in;
                    end
                end
                LOAD: begin
                    plat_y[idx] <= load_y;
                    plat_x[idx] <= gen_x;
                    lfsr        <= lfsr_next;
                    idx         <= idx + 4'd1;
                    if (last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                SCROLL: begin
                    if (s > 10'(Y_MAX)) begin
                        plat_y[idx] <= 9'(s - 10'(Y_SPAN));
                        plat_x[idx] <= gen_x;
                        lfsr        <= lfsr_next;
                    end else begin
                        plat_y[idx] <= s[8:0];
                    end
                    idx <= idx + 4'd1;
                    if (last)
                        state <= DONE;
                end
                DONE: begin
                    trigger      <= 1'b1;
                    served       <= 1'b1;
                    scroll_total <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
                    state        <= IDLE;
                    busy         <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_platform_scroller.sv
// Scoreboard bench for platform_scroller: stimulus pushes expected field snapshots,
// a monitor checks them each time the block drops busy.
`timescale 1ns/1ps
module tb_platform_scroller;

    logic              frame_clk = 1'b0;
    logic              Reset = 1'b1;
    logic              loadplat = 1'b0;
    logic              refresh_en = 1'b0;
    logic [9:0]        plat_temp_Y = '0;
    logic              trigger;
    logic              busy;
    logic [15:0][8:0]  plat_x;
    logic [15:0][8:0]  plat_y;
    logic [15:0]       scroll_total;

    platform_scroller #(.N_PLAT(16), .LFSR_SEED(16'hACE1)) dut (
        .frame_clk    (frame_clk),
        .Reset        (Reset),
        .loadplat     (loadplat),
        .refresh_en   (refresh_en),
        .plat_temp_Y  (plat_temp_Y),
        .trigger      (trigger),
        .busy         (busy),
        .plat_x       (plat_x),
        .plat_y       (plat_y),
        .scroll_total (scroll_total)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct packed {
        logic [15:0][8:0] y;
        logic [15:0][8:0] x;
        logic [15:0]      tot;
        logic             trig;
        logic [7:0]       blen;
    } exp_t;

    exp_t             q[$];
    int               checks = 0;
    int               failures = 0;
    int               exp_trigs = 0;
    int               trig_count = 0;
    logic [15:0][8:0] my, mx;
    logic [15:0]      mtot;
    logic [15:0]      mlfsr;

    task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] m_genx(input logic [15:0] l);
        logic [8:0] v;
        v = l[8:0];
        if (v >= 9'd448) v = v - 9'd256;
        return 9'd64 + v;
    endfunction

    function automatic logic [15:0] m_step(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    endfunction

    function automatic logic [5:0] m_d(input logic [9:0] p);
        int v;
        if (!p[9]) return 6'd0;
        v = (1024 - int'(p)) * 4;
        return (v > 63) ? 6'd63 : 6'(v);
    endfunction

    task automatic model_load();
        exp_t e;
        mtot = '0;
        for (int i = 0; i < 16; i++) begin
            my[i] = 9'(15 + 30 * i);
            mx[i] = m_genx(mlfsr);
            mlfsr = m_step(mlfsr);
        end
        e = '{y: my, x: mx, tot: mtot, trig: 1'b0, blen: 8'd16};
        q.push_back(e);
    endtask

    task automatic model_scroll(input logic [9:0] py);
        exp_t e;
        int   dd, s, t;
        dd = int'(m_d(py));
        for (int i = 0; i < 16; i++) begin
            s = int'(my[i]) + dd;
            if (s > 479) begin
                my[i] = 9'(s - 480);
                mx[i] = m_genx(mlfsr);
                mlfsr = m_step(mlfsr);
            end else begin
                my[i] = 9'(s);
            end
        end
        t = int'(mtot) + dd;
        mtot = (t > 65535) ? 16'hFFFF : 16'(t);
        exp_trigs++;
        e = '{y: my, x: mx, tot: mtot, trig: 1'b1, blen: 8'd17};
        q.push_back(e);
    endtask

    // Monitor: every busy falling edge ends an operation and retires one entry
    logic prev_busy = 1'b0;
    int   blen = 0;
    always @(negedge frame_clk) begin
        if (Reset) begin
            prev_busy = 1'b0;
            blen = 0;
        end else begin
            if (trigger) trig_count++;
            if (busy) blen++;
            if (prev_busy && !busy) begin
                if (q.size() == 0) begin
                    chk("unexpected_op_end", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("busy_len", 144'(blen), 144'(e.blen));
                    chk("trigger_at_end", 144'(trigger), 144'(e.trig));
                    chk("plat_y", plat_y, e.y);
                    chk("plat_x", plat_x, e.x);
                    chk("scroll_total", 144'(scroll_total), 144'(e.tot));
                end
                blen = 0;
            end
            prev_busy = busy;
        end
    end

    task automatic wait_busy(input string name);
        int n = 0;
        while (busy !== 1'b1 && n < 50) begin
            @(negedge frame_clk);
            n++;
        end
        if (n >= 50) chk({name, "_start_timeout"}, 144'(busy), 144'(1));
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge frame_clk);
            n++;
        end
        if (n >= 100) chk({name, "_end_timeout"}, 144'(busy), 144'(0));
    endtask

    task automatic do_load();
        @(posedge frame_clk); #1 loadplat = 1'b1;
        model_load();
        @(posedge frame_clk); #1 loadplat = 1'b0;
        wait_busy("load");
        wait_idle("load");
    endtask

    task automatic do_scroll(input logic [9:0] py);
        @(posedge frame_clk); #1 refresh_en = 1'b1; plat_temp_Y = py;
        model_scroll(py);
        wait_busy("scroll");
        wait_idle("scroll");
        @(posedge frame_clk); #1 refresh_en = 1'b0; plat_temp_Y = '0;
        @(posedge frame_clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bad;
        int extra;
        mlfsr = 16'hACE1;
        mtot  = '0;
        my    = '0;
        mx    = '0;
        repeat (3) @(posedge frame_clk);
        #1 Reset = 1'b0;
        @(negedge frame_clk);
        chk("reset_plat_y", plat_y, '0);
        chk("reset_plat_x", plat_x, '0);
        chk("reset_total", 144'(scroll_total), 144'(0));
        chk("reset_busy", 144'(busy), 144'(0));
        chk("reset_trigger", 144'(trigger), 144'(0));

        do_load();
        chk("load_y0", 144'(plat_y[0]), 144'(15));
        chk("load_y15", 144'(plat_y[15]), 144'(465));
        bad = 0;
        for (int i = 0; i < 16; i++) if (plat_x[i] < 9'd64) bad++;
        chk("load_x_range", 144'(bad), 144'(0));

        do_scroll(10'h3FD);
        chk("scroll1_y0", 144'(plat_y[0]), 144'(27));
        chk("scroll1_y15", 144'(plat_y[15]), 144'(477));
        chk("scroll1_total", 144'(scroll_total), 144'(12));

        do_scroll(10'h3FD);
        chk("scroll2_y15_respawn", 144'(plat_y[15]), 144'(9));
        chk("scroll2_y14", 144'(plat_y[14]), 144'(459));
        chk("scroll2_total", 144'(scroll_total), 144'(24));

        do_scroll(10'h005);
        chk("d0_total", 144'(scroll_total), 144'(24));

        do_scroll(10'h3C0);
        chk("clamp_total", 144'(scroll_total), 144'(87));

        // Held request: one scroll per high period, re-armed by a one-cycle drop
        @(posedge frame_clk); #1 refresh_en = 1'b1; plat_temp_Y = 10'h3FF;
        model_scroll(10'h3FF);
        wait_busy("held");
        wait_idle("held");
        extra = 0;
        repeat (10) begin
            @(negedge frame_clk);
            if (busy) extra++;
        end
        chk("held_no_rescroll", 144'(extra), 144'(0));
        @(posedge frame_clk); #1 refresh_en = 1'b0;
        @(posedge frame_clk); #1 refresh_en = 1'b1;
        model_scroll(10'h3FF);
        wait_busy("rearm");
        wait_idle("rearm");
        @(posedge frame_clk); #1 refresh_en = 1'b0;
        @(posedge frame_clk); #1;

        // Request raised during LOAD is taken right after LOAD ends
        @(posedge frame_clk); #1 loadplat = 1'b1;
        model_load();
        @(posedge frame_clk); #1 loadplat = 1'b0;
        repeat (5) @(posedge frame_clk);
        #1 refresh_en = 1'b1; plat_temp_Y = 10'h3FE;
        model_scroll(10'h3FE);
        wait_idle("load2");
        @(negedge frame_clk);
        chk("scroll_after_load", 144'(busy), 144'(1));
        wait_idle("scroll_after_load");
        chk("after_load_y0", 144'(plat_y[0]), 144'(23));
        chk("after_load_y15", 144'(plat_y[15]), 144'(473));
        chk("after_load_total", 144'(scroll_total), 144'(8));
        @(posedge frame_clk); #1 refresh_en = 1'b0;
        @(posedge frame_clk); #1;

        // Reset in the middle of a scroll, after idx 0..6 have been written
        refresh_en = 1'b1; plat_temp_Y = 10'h3FD;
        wait_busy("abort");
        repeat (7) @(posedge frame_clk);
        #1 Reset = 1'b1;
        @(negedge frame_clk);
        chk("abort_plat_y", plat_y, '0);
        chk("abort_plat_x", plat_x, '0);
        chk("abort_total", 144'(scroll_total), 144'(0));
        chk("abort_busy", 144'(busy), 144'(0));
        chk("abort_trigger", 144'(trigger), 144'(0));
        @(posedge frame_clk); #1 Reset = 1'b0; refresh_en = 1'b0;
        repeat (3) @(negedge frame_clk);

        chk("trigger_count", 144'(trig_count), 144'(exp_trigs));
        chk("scoreboard_empty", 144'(q.size()), 144'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
